// File: rtl/ecc_op_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// ecc_op_sequencer_pkg
// Shared definitions for the ECC operation sequencer and its APB register bank:
// register byte offsets, operation opcodes, codeword width codes, FSM state
// encoding and a helper that turns a width code into a codeword bit mask.
// -----------------------------------------------------------------------------
package ecc_op_sequencer_pkg;

    // Register byte offsets; only bits [3:2] are decoded on the bus.
    localparam logic [3:0] REG_CTRL     = 4'h0;
    localparam logic [3:0] REG_DATA_IN  = 4'h4;
    localparam logic [3:0] REG_CW_WIDTH = 4'h8;
    localparam logic [3:0] REG_NOISE    = 4'hC;

    // CTRL[1:0] opcodes. OP_RSVD is never launched and never stored.
    typedef enum logic [1:0] {
        OP_ENC  = 2'd0,
        OP_DEC  = 2'd1,
        OP_FULL = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    // CODEWORD_WIDTH codes; any value of CW_32 or above selects 32 bits.
    localparam logic [1:0] CW_8  = 2'd0;
    localparam logic [1:0] CW_16 = 2'd1;
    localparam logic [1:0] CW_32 = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_CHAN    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Mask of the bits that belong to the active codeword.
    function automatic logic [31:0] cw_mask(input logic [31:0] width_code);
        logic [31:0] mask;
        if (width_code == {30'd0, CW_8}) begin
            mask = 32'h0000_00FF;
        end else if (width_code == {30'd0, CW_16}) begin
            mask = 32'h0000_FFFF;
        end else begin
            mask = 32'hFFFF_FFFF;
        end
        return mask;
    endfunction

endpackage

// File: rtl/ecc_op_sequencer_apb_regs.sv
// -----------------------------------------------------------------------------
// ecc_apb_regs
// APB register bank for the ECC sequencer: CTRL, DATA_IN, CODEWORD_WIDTH and
// NOISE. Zero-wait-state writes commit when PSEL, PENABLE and PWRITE are all
// high, unless an operation is running (busy). A CTRL write of the reserved
// opcode is dropped entirely. PRDATA is a combinational read mux gated by PSEL.
//
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   PADDR..PWDATA   APB slave inputs; PRDATA read data
//   busy            sequencer busy, blocks every register write
//   ctrl            stored opcode (CTRL[1:0])
//   data_in         DATA_IN register
//   cw_width        CODEWORD_WIDTH register
//   noise           NOISE register
//   launch          one-cycle strobe: an accepted CTRL write with a valid opcode
// -----------------------------------------------------------------------------
module ecc_apb_regs
    import ecc_op_sequencer_pkg::*;
#(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [AMBA_WORD-1:0]       PWDATA,
    output logic [AMBA_WORD-1:0]       PRDATA,
    input  logic                       busy,
    output logic [1:0]                 ctrl,
    output logic [AMBA_WORD-1:0]       data_in,
    output logic [AMBA_WORD-1:0]       cw_width,
    output logic [AMBA_WORD-1:0]       noise,
    output logic                       launch
);

    localparam int NUM_REGS = 4;

    logic [1:0]                     addr_sel;
    logic                           wr_en;
    logic                           ctrl_ok;
    logic [NUM_REGS*AMBA_WORD-1:0]  word_flat;
    logic                           unused_paddr;

    assign addr_sel = PADDR[3:2];
    assign wr_en    = PSEL & PENABLE & PWRITE & ~busy;
    assign ctrl_ok  = (op_e'(PWDATA[1:0]) != OP_RSVD);
    assign launch   = wr_en && (addr_sel == REG_CTRL[3:2]) && ctrl_ok;

    // Byte-lane bits and upper address bits take no part in decoding.
    assign unused_paddr = ^{PADDR[AMBA_ADDR_WIDTH-1:4], PADDR[1:0]};

    // One register per word offset; CTRL only keeps its two opcode bits and
    // only accepts a write that carries a valid opcode.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic                 wr_hit;
        logic [AMBA_WORD-1:0] wr_value;
        logic [AMBA_WORD-1:0] word_reg;

        if (gi == 0) begin : g_ctrl
            assign wr_hit   = wr_en && (addr_sel == 2'(gi)) && ctrl_ok;
            assign wr_value = {{(AMBA_WORD-2){1'b0}}, PWDATA[1:0]};
        end else begin : g_word
            assign wr_hit   = wr_en && (addr_sel == 2'(gi));
            assign wr_value = PWDATA;
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                word_reg <= '0;
            end else if (wr_hit) begin
                word_reg <= wr_value;
            end
        end

        assign word_flat[gi*AMBA_WORD +: AMBA_WORD] = word_reg;
    end

    assign ctrl     = word_flat[1:0];
    assign data_in  = word_flat[1*AMBA_WORD +: AMBA_WORD];
    assign cw_width = word_flat[2*AMBA_WORD +: AMBA_WORD];
    assign noise    = word_flat[3*AMBA_WORD +: AMBA_WORD];

    always_comb begin
        PRDATA = '0;
        if (PSEL) begin
            PRDATA = word_flat[addr_sel*AMBA_WORD +: AMBA_WORD];
        end
    end

endmodule

// File: rtl/ecc_op_sequencer.sv
// -----------------------------------------------------------------------------
// ecc_op_sequencer
// APB-controlled sequencer for the ECC datapath. A valid CTRL write launches an
// encode, decode or full-channel (encode, add noise, decode) operation. The
// block drives the external combinational encoder/decoder from registers,
// captures their results and raises operation_done for one cycle.
//
// Latency from the CTRL write cycle T: done in T+3 for encode/decode,
// T+4 for full channel (extra CHAN cycle to form the noisy codeword).
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   PADDR..PRDATA            APB slave (zero wait states)
//   enc_info, enc_cw_width   encoder inputs; enc_codeword encoder result
//   dec_codeword             decoder input; dec_info/dec_num_err decoder result
//   data_out, num_of_errors  result of the last completed operation
//   operation_done           one-cycle completion pulse
//   busy                     high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module ecc_op_sequencer
    import ecc_op_sequencer_pkg::*;
#(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [AMBA_WORD-1:0]       PWDATA,
    output logic [AMBA_WORD-1:0]       PRDATA,
    output logic [DATA_WIDTH-1:0]      enc_info,
    output logic [AMBA_WORD-1:0]       enc_cw_width,
    input  logic [DATA_WIDTH-1:0]      enc_codeword,
    output logic [DATA_WIDTH-1:0]      dec_codeword,
    input  logic [DATA_WIDTH-1:0]      dec_info,
    input  logic [1:0]                 dec_num_err,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       operation_done,
    output logic [1:0]                 num_of_errors,
    output logic                       busy
);

    logic [1:0]            ctrl;
    logic [AMBA_WORD-1:0]  data_in;
    logic [AMBA_WORD-1:0]  cw_width;
    logic [AMBA_WORD-1:0]  noise;
    logic                  launch;
    op_e                   op;

    state_e                state_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic [DATA_WIDTH-1:0] data_out_reg;
    logic [1:0]            num_err_reg;
    logic [DATA_WIDTH-1:0] enc_info_reg;
    logic [AMBA_WORD-1:0]  enc_cw_width_reg;
    logic [DATA_WIDTH-1:0] dec_codeword_reg;

    logic [31:0]           mask_full;
    logic [DATA_WIDTH-1:0] noise_masked;

    ecc_apb_regs #(
        .AMBA_WORD       (AMBA_WORD),
        .AMBA_ADDR_WIDTH (AMBA_ADDR_WIDTH)
    ) u_regs (
        .clk      (clk),
        .rst      (rst),
        .PADDR    (PADDR),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .busy     (busy_reg),
        .ctrl     (ctrl),
        .data_in  (data_in),
        .cw_width (cw_width),
        .noise    (noise),
        .launch   (launch)
    );

    // CTRL cannot change while busy, so the stored opcode is stable for the
    // whole operation.
    assign op = op_e'(ctrl);

    // Noise outside the active codeword is dropped so it cannot corrupt the
    // unused upper bits seen by the decoder. The width is taken from the
    // launched copy that also feeds the encoder.
    assign mask_full    = cw_mask(enc_cw_width_reg);
    assign noise_masked = noise[DATA_WIDTH-1:0] & mask_full[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg        <= ST_IDLE;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            data_out_reg     <= '0;
            num_err_reg      <= '0;
            enc_info_reg     <= '0;
            enc_cw_width_reg <= '0;
            dec_codeword_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (launch) begin
                        state_reg <= ST_LAUNCH;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    // Present the operands; results are sampled a cycle later.
                    enc_info_reg     <= data_in[DATA_WIDTH-1:0];
                    enc_cw_width_reg <= cw_width;
                    dec_codeword_reg <= data_in[DATA_WIDTH-1:0];
                    state_reg        <= (op == OP_FULL) ? ST_CHAN : ST_CAPTURE;
                end
                ST_CHAN: begin
                    // dec_codeword_reg doubles as the channel word register.
                    dec_codeword_reg <= enc_codeword ^ noise_masked;
                    state_reg        <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (op == OP_ENC) begin
                        data_out_reg <= enc_codeword;
                        num_err_reg  <= 2'd0;
                    end else begin
                        data_out_reg <= dec_info;
                        num_err_reg  <= dec_num_err;
                    end
                    done_reg  <= 1'b1;
                    state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign enc_info       = enc_info_reg;
    assign enc_cw_width   = enc_cw_width_reg;
    assign dec_codeword   = dec_codeword_reg;
    assign data_out       = data_out_reg;
    assign num_of_errors  = num_err_reg;
    assign operation_done = done_reg;
    assign busy           = busy_reg;

endmodule

// File: tb/tb_ecc_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ecc_op_sequencer
// Bench for ecc_op_sequencer. An extended Hamming(8,4) encoder/decoder stands
// in for the 8-bit datapath; wider widths use a simple invertible stand-in
// code. Operations are checked against a transaction-level reference.
// -----------------------------------------------------------------------------
module tb_ecc_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] PADDR;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic [31:0] enc_info, enc_cw_width, enc_codeword;
    logic [31:0] dec_codeword, dec_info;
    logic [1:0]  dec_num_err;
    logic [31:0] data_out;
    logic        operation_done;
    logic [1:0]  num_of_errors;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_done_cyc = -100;

    always #5 clk = ~clk;

    ecc_op_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .PADDR          (PADDR),
        .PSEL           (PSEL),
        .PENABLE        (PENABLE),
        .PWRITE         (PWRITE),
        .PWDATA         (PWDATA),
        .PRDATA         (PRDATA),
        .enc_info       (enc_info),
        .enc_cw_width   (enc_cw_width),
        .enc_codeword   (enc_codeword),
        .dec_codeword   (dec_codeword),
        .dec_info       (dec_info),
        .dec_num_err    (dec_num_err),
        .data_out       (data_out),
        .operation_done (operation_done),
        .num_of_errors  (num_of_errors),
        .busy           (busy)
    );

    // ---------------- datapath models ----------------
    function automatic logic [31:0] wmask(input logic [31:0] wc);
        if (wc == 32'd0) return 32'h0000_00FF;
        if (wc == 32'd1) return 32'h0000_FFFF;
        return 32'hFFFF_FFFF;
    endfunction

    // 8-bit: {d3,d2,d1,d0,p2,p1,p0,pall}; wider: XOR pattern stand-in.
    function automatic logic [31:0] enc_f(input logic [31:0] info, input logic [31:0] wc);
        logic [3:0] d;
        logic p0, p1, p2, pa;
        if (wc != 32'd0) return (info ^ 32'hA5A5_A5A5) & wmask(wc);
        d  = info[3:0];
        p0 = d[3] ^ d[2] ^ d[1];
        p1 = d[3] ^ d[2] ^ d[0];
        p2 = d[2] ^ d[1] ^ d[0];
        pa = ^{d, p2, p1, p0};
        return {24'h0, d, p2, p1, p0, pa};
    endfunction

    // Returns {num_err, info}. Bits set above the width count as uncorrectable.
    function automatic logic [33:0] dec_f(input logic [31:0] cw, input logic [31:0] wc);
        logic [31:0] m;
        logic [3:0]  d;
        logic [2:0]  s;
        logic        par;
        m = wmask(wc);
        if ((cw & ~m) != 32'h0) return {2'd2, 32'h0};
        if (wc != 32'd0) return {1'b0, ^cw, (cw ^ 32'hA5A5_A5A5) & m};
        d    = cw[7:4];
        s[0] = cw[1] ^ d[3] ^ d[2] ^ d[1];
        s[1] = cw[2] ^ d[3] ^ d[2] ^ d[0];
        s[2] = cw[3] ^ d[2] ^ d[1] ^ d[0];
        par  = ^cw[7:0];
        if (s == 3'd0) return {1'b0, par, 28'h0, d};
        if (!par) return {2'd2, 28'h0, d};
        case (s)
            3'd3:    d[3] = ~d[3];
            3'd7:    d[2] = ~d[2];
            3'd5:    d[1] = ~d[1];
            3'd6:    d[0] = ~d[0];
            default: ;
        endcase
        return {2'd1, 28'h0, d};
    endfunction

    logic [33:0] dec_res;
    always_comb begin
        enc_codeword = enc_f(enc_info, enc_cw_width);
        dec_res      = dec_f(dec_codeword, enc_cw_width);
    end
    assign dec_info    = dec_res[31:0];
    assign dec_num_err = dec_res[33:32];

    // Transaction-level expectation: {num_err, data_out}.
    function automatic logic [33:0] ref_op(input logic [1:0] op, input logic [31:0] wc,
                                           input logic [31:0] data, input logic [31:0] noise);
        if (op == 2'd0) return {2'd0, enc_f(data, wc)};
        if (op == 2'd1) return dec_f(data, wc);
        return dec_f(enc_f(data, wc) ^ (noise & wmask(wc)), wc);
    endfunction

    // ---------------- monitors ----------------
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (operation_done === 1'b1) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called #1 after a clock edge; returns #1 after the commit edge.
    task automatic apb_write(input logic [3:0] addr, input logic [31:0] data);
        PADDR = {16'h0, addr}; PWDATA = data; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] addr, output logic [31:0] data);
        PADDR = {16'h0, addr}; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        #1 data = PRDATA;
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] wc, input logic [31:0] data,
                          input logic [31:0] noise, input logic [31:0] exp_data,
                          input logic [1:0] exp_err, input int lat);
        int d0, c0;
        apb_write(4'h8, wc);
        apb_write(4'h4, data);
        apb_write(4'hC, noise);
        d0 = done_cnt;
        apb_write(4'h0, {30'h0, op});
        c0 = cyc;
        check("busy_after_launch", busy, 1);
        repeat (lat + 3) @(posedge clk);
        #1;
        check("done_pulses", done_cnt - d0, 1);
        check("done_latency", last_done_cyc - c0 + 1, lat);
        check("data_out", data_out, exp_data);
        check("num_of_errors", num_of_errors, exp_err);
        check("busy_idle", busy, 0);
        check("enc_info", enc_info, data);
        check("enc_cw_width", enc_cw_width, wc);
        $display("[TB] op=%0d wc=%0d data=0x%0h noise=0x%0h -> data_out=0x%0h err=%0d (exp 0x%0h/%0d)",
                 op, wc, data, noise, data_out, num_of_errors, exp_data, exp_err);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] wc;
        logic [31:0] data;
        logic [31:0] noise;
        logic [31:0] exp_data;
        logic [1:0]  exp_err;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] rd;
        logic [33:0] exp;
        int d0, c0;

        vecs[0] = '{2'd0, 32'd0, 32'h0000_000B, 32'h0,         32'h0000_00B1, 2'd0, 3};
        vecs[1] = '{2'd2, 32'd0, 32'h0000_000B, 32'h04,        32'h0000_000B, 2'd1, 4};
        vecs[2] = '{2'd2, 32'd0, 32'h0000_000B, 32'h06,        32'h0000_000B, 2'd2, 4};
        vecs[3] = '{2'd2, 32'd0, 32'h0000_000B, 32'hFFFF_FF00, 32'h0000_000B, 2'd0, 4};
        vecs[4] = '{2'd1, 32'd0, 32'h0000_00B1, 32'h0,         32'h0000_000B, 2'd0, 3};
        vecs[5] = '{2'd1, 32'd0, 32'h0000_00B0, 32'h0,         32'h0000_000B, 2'd1, 3};
        vecs[6] = '{2'd0, 32'd1, 32'h0000_1234, 32'h0,         32'h0000_B791, 2'd0, 3};
        vecs[7] = '{2'd1, 32'd1, 32'h0000_B791, 32'h0,         32'h0000_1234, 2'd1, 3};
        vecs[8] = '{2'd0, 32'd5, 32'h0000_00FF, 32'h0,         32'hA5A5_A55A, 2'd0, 3};
        vecs[9] = '{2'd2, 32'd2, 32'h1234_5678, 32'h0001_0000, 32'h1235_5678, 2'd0, 4};

        rst = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Reset state
        for (int i = 0; i < 4; i++) begin
            apb_read(4'(i * 4), rd);
            check("reset_reg_read", rd, 0);
        end
        check("reset_busy", busy, 0);
        check("reset_data_out", data_out, 0);
        check("reset_num_err", num_of_errors, 0);
        check("reset_done", operation_done, 0);
        check("reset_enc_info", enc_info, 0);

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].wc, vecs[i].data, vecs[i].noise,
                   vecs[i].exp_data, vecs[i].exp_err, vecs[i].lat);
        end

        // Busy lockout: back-to-back access phases during an encode
        apb_write(4'h8, 32'd0);
        apb_write(4'h4, 32'hB);
        d0 = done_cnt;
        apb_write(4'h0, 32'd0);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 20'h4; PWDATA = 32'h5;
        @(posedge clk); #1;
        PADDR = 20'h0; PWDATA = 32'h1;
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("lockout_done_pulses", done_cnt - d0, 1);
        check("lockout_data_out", data_out, 32'hB1);
        apb_read(4'h4, rd);
        check("lockout_data_in", rd, 32'hB);
        apb_read(4'h0, rd);
        check("lockout_ctrl", rd, 0);
        $display("[TB] lockout: data_out=0x%0h DATA_IN=0x%0h", data_out, 32'hB);

        // Reserved opcode
        apb_write(4'h0, 32'd2);
        repeat (6) @(posedge clk);
        #1;
        d0 = done_cnt;
        apb_write(4'h0, 32'd3);
        check("rsvd_busy", busy, 0);
        repeat (6) @(posedge clk);
        #1;
        check("rsvd_no_done", done_cnt - d0, 0);
        apb_read(4'h0, rd);
        check("rsvd_ctrl_kept", rd, 2);
        $display("[TB] reserved opcode: CTRL reads %0d", rd);

        // Randomized operations against the reference
        for (int n = 0; n < 30; n++) begin
            logic [1:0]  op;
            logic [31:0] wc, data, noise;
            int          width;
            op    = 2'($urandom_range(0, 2));
            wc    = 32'($urandom_range(0, 3));
            width = (wc == 0) ? 8 : (wc == 1) ? 16 : 32;
            data  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & wmask(wc));
            if (op == 2'd1 && $urandom_range(0, 1) == 1)
                data = enc_f($urandom, wc) ^ (32'h1 << $urandom_range(0, width - 1));
            noise = ($urandom_range(0, 1) == 1) ? (32'h1 << $urandom_range(0, width - 1)) : $urandom;
            exp   = ref_op(op, wc, data, noise);
            run_op(op, wc, data, noise, exp[31:0], exp[33:32], (op == 2'd2) ? 4 : 3);
        end

        // Reset during CHAN
        apb_write(4'h8, 32'd0);
        apb_write(4'h4, 32'hB);
        apb_write(4'hC, 32'h4);
        d0 = done_cnt;
        apb_write(4'h0, 32'd2);
        c0 = cyc;
        @(posedge clk); #1;
        check("chan_busy", busy, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_done", operation_done, 0);
        check("abort_data_out", data_out, 0);
        check("abort_num_err", num_of_errors, 0);
        check("abort_enc_info", enc_info, 0);
        check("abort_dec_codeword", dec_codeword, 0);
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - d0, 0);
        for (int i = 0; i < 4; i++) begin
            apb_read(4'(i * 4), rd);
            check("abort_reg_read", rd, 0);
        end
        $display("[TB] reset in CHAN at cycle %0d: busy=%0d", c0 + 1, busy);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
